// File: rtl/sdram_rd_unpack.sv
// Read-side byte serializer: buffers SDRAM read words in a FIFO and hands
// them to the UART transmitter one byte at a time, MSB first.
module sdram_rd_unpack #(
  parameter int unsigned DW         = 48,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned AW         = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] sd_data,
  input  logic          sd_data_vld,
  input  logic          rdy,
  output logic [7:0]    dout,
  output logic          dout_vld,
  output logic [AW:0]   fifo_cnt,
  output logic          busy,
  output logic          ovf
);

  localparam int unsigned NB  = DW / 8;
  localparam int unsigned BCW = $clog2(NB + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   mem [FIFO_DEPTH];
  logic [AW:0]     wr_ptr_q, wr_ptr_d;
  logic [AW:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]     used;
  logic [DW-1:0]   shift_q, shift_d;
  logic [BCW-1:0]  bcnt_q, bcnt_d;
  logic            gap_q, gap_d;
  logic [7:0]      dout_d;
  logic            dout_vld_d;
  logic            busy_d;
  logic            full, empty, push, pop;

  // Occupancy from the extra-bit pointers; full is judged before any same-cycle pop
  assign used  = wr_ptr_q - rd_ptr_q;
  assign full  = (used == (AW+1)'(FIFO_DEPTH));
  assign empty = (used == '0);
  assign push  = sd_data_vld & ~full;

  // Word storage; no reset needed since occupancy is tracked by the pointers
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q[AW-1:0]] <= sd_data;
    end
  end

  // Next-state, datapath and output decode
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bcnt_d     = bcnt_q;
    gap_d      = gap_q;
    dout_d     = dout;
    dout_vld_d = 1'b0;
    pop        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr_q[AW-1:0]];
          bcnt_d  = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (rdy) begin
          dout_d     = shift_q[DW-1 -: 8];
          dout_vld_d = 1'b1;
          shift_d    = {shift_q[DW-9:0], 8'h00};
          bcnt_d     = bcnt_q + BCW'(1);
          gap_d      = 1'b0;
          state_d    = GAP;
        end
      end
      GAP: begin
        // Two idle cycles give TX time to drop its registered rdy
        if (gap_q) begin
          gap_d   = 1'b0;
          state_d = (bcnt_q < BCW'(NB)) ? SEND : IDLE;
        end else begin
          gap_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    wr_ptr_d = push ? (wr_ptr_q + (AW+1)'(1)) : wr_ptr_q;
    rd_ptr_d = pop  ? (rd_ptr_q + (AW+1)'(1)) : rd_ptr_q;
    busy_d   = (state_d != IDLE) || (wr_ptr_d != rd_ptr_d);
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      bcnt_q   <= '0;
      gap_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      dout     <= '0;
      dout_vld <= 1'b0;
      fifo_cnt <= '0;
      busy     <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      bcnt_q   <= bcnt_d;
      gap_q    <= gap_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      dout     <= dout_d;
      dout_vld <= dout_vld_d;
      fifo_cnt <= wr_ptr_d - rd_ptr_d;
      busy     <= busy_d;
      ovf      <= ovf | (sd_data_vld & full);
    end
  end

endmodule

// File: tb/tb_sdram_rd_unpack.sv
// Self-checking bench for sdram_rd_unpack: fixed vector table, directed
// corner sequences and a randomized run against a queue-based model.
module tb_sdram_rd_unpack;

  localparam int unsigned DW    = 48;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;
  localparam int unsigned NB    = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] sd_data = '0;
  logic          sd_data_vld = 1'b0;
  logic          rdy = 1'b0;
  logic [7:0]    dout;
  logic          dout_vld;
  logic [AW:0]   fifo_cnt;
  logic          busy;
  logic          ovf;

  int n_chk  = 0;
  int n_fail = 0;

  sdram_rd_unpack #(.DW(DW), .FIFO_DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .sd_data(sd_data), .sd_data_vld(sd_data_vld),
    .rdy(rdy), .dout(dout), .dout_vld(dout_vld), .fifo_cnt(fifo_cnt),
    .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic logic [7:0] byte_of(logic [47:0] w, int k);
    return 8'(w >> (8 * (5 - k)));
  endfunction

  // ---------------- reference model ----------------
  // Words wait in mq; the word being serialized sits as a byte queue in hb.
  // ready_at is the earliest edge at which the next pop or strobe may happen.
  logic [47:0] mq[$];
  logic [7:0]  hb[$];
  int          cyc = 0;
  int          ready_at = 0;
  logic [7:0]  m_dout = '0;
  logic        m_vld = 1'b0;
  logic        m_ovf = 1'b0;
  logic        m_busy = 1'b0;
  logic [7:0]  got[$];

  function automatic void model_reset();
    mq.delete();
    hb.delete();
    cyc      = 0;
    ready_at = 0;
    m_dout   = '0;
    m_vld    = 1'b0;
    m_ovf    = 1'b0;
    m_busy   = 1'b0;
  endfunction

  function automatic void model_step();
    bit          full_pre;
    bit          empty_pre;
    logic [47:0] w;
    full_pre  = (mq.size() == int'(DEPTH));
    empty_pre = (mq.size() == 0);
    if (sd_data_vld && full_pre) m_ovf = 1'b1;
    m_vld = 1'b0;
    if (hb.size() == 0) begin
      if (cyc >= ready_at && !empty_pre) begin
        w = mq.pop_front();
        for (int k = 0; k < int'(NB); k++) hb.push_back(byte_of(w, k));
        ready_at = cyc + 1;
      end
    end else if (cyc >= ready_at && rdy) begin
      m_dout   = hb.pop_front();
      m_vld    = 1'b1;
      ready_at = cyc + 3;
    end
    if (sd_data_vld && !full_pre) mq.push_back(sd_data);
    m_busy = (hb.size() != 0) || (mq.size() != 0) || (cyc + 1 < ready_at);
    cyc++;
  endfunction

  // Cycle checker: outputs vs model, sampled 1 ns after each edge
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      model_step();
      #1;
      check("mdl_dout_vld", 64'(dout_vld), 64'(m_vld));
      check("mdl_dout", 64'(dout), 64'(m_dout));
      check("mdl_fifo_cnt", 64'(fifo_cnt), 64'(mq.size()));
      check("mdl_busy", 64'(busy), 64'(m_busy));
      check("mdl_ovf", 64'(ovf), 64'(m_ovf));
      if (dout_vld) got.push_back(dout);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push_word(input logic [47:0] w);
    sd_data_vld = 1'b1;
    sd_data     = w;
    step();
    sd_data_vld = 1'b0;
  endtask

  task automatic do_reset();
    sd_data_vld = 1'b0;
    rdy         = 1'b0;
    rst_n       = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    got.delete();
  endtask

  task automatic wait_strobes(input int n, input int budget);
    int seen = 0;
    int t = 0;
    while (seen < n && t < budget) begin
      step();
      t++;
      if (dout_vld) seen++;
    end
    check("wait_strobes_timeout", 64'(seen), 64'(n));
  endtask

  task automatic drain(input int budget);
    int t = 0;
    while (busy && t < budget) begin
      step();
      t++;
    end
    check("drain_timeout", 64'(busy), 64'(0));
  endtask

  task automatic check_got(input logic [47:0] ws[$]);
    logic [7:0] exp[$];
    foreach (ws[i]) for (int k = 0; k < int'(NB); k++) exp.push_back(byte_of(ws[i], k));
    check("byte_count", 64'(got.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      check("byte_stream", 64'(got[i]), 64'(exp[i]));
  endtask

  function automatic logic [47:0] rand_word();
    return {16'($urandom), 32'($urandom)};
  endfunction

  typedef struct {
    logic       vld;
    logic       exp_vld;
    logic [7:0] exp_dout;
    logic [4:0] exp_cnt;
    logic       exp_busy;
  } vec_t;

  vec_t tbl[22];

  initial begin
    logic [47:0] ws[$];
    logic [47:0] w;
    int          cnt;

    // Single word 0123_4567_89AB pushed at edge 0 with rdy held high
    tbl[0]  = '{1'b1, 1'b0, 8'h00, 5'd1, 1'b1};
    tbl[1]  = '{1'b0, 1'b0, 8'h00, 5'd0, 1'b1};
    tbl[2]  = '{1'b0, 1'b1, 8'h01, 5'd0, 1'b1};
    tbl[3]  = '{1'b0, 1'b0, 8'h01, 5'd0, 1'b1};
    tbl[4]  = '{1'b0, 1'b0, 8'h01, 5'd0, 1'b1};
    tbl[5]  = '{1'b0, 1'b1, 8'h23, 5'd0, 1'b1};
    tbl[6]  = '{1'b0, 1'b0, 8'h23, 5'd0, 1'b1};
    tbl[7]  = '{1'b0, 1'b0, 8'h23, 5'd0, 1'b1};
    tbl[8]  = '{1'b0, 1'b1, 8'h45, 5'd0, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 8'h45, 5'd0, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 8'h45, 5'd0, 1'b1};
    tbl[11] = '{1'b0, 1'b1, 8'h67, 5'd0, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 8'h67, 5'd0, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 8'h67, 5'd0, 1'b1};
    tbl[14] = '{1'b0, 1'b1, 8'h89, 5'd0, 1'b1};
    tbl[15] = '{1'b0, 1'b0, 8'h89, 5'd0, 1'b1};
    tbl[16] = '{1'b0, 1'b0, 8'h89, 5'd0, 1'b1};
    tbl[17] = '{1'b0, 1'b1, 8'hAB, 5'd0, 1'b1};
    tbl[18] = '{1'b0, 1'b0, 8'hAB, 5'd0, 1'b1};
    tbl[19] = '{1'b0, 1'b0, 8'hAB, 5'd0, 1'b0};
    tbl[20] = '{1'b0, 1'b0, 8'hAB, 5'd0, 1'b0};
    tbl[21] = '{1'b0, 1'b0, 8'hAB, 5'd0, 1'b0};

    // Reset values
    do_reset();
    check("rst_dout", 64'(dout), 64'(0));
    check("rst_dout_vld", 64'(dout_vld), 64'(0));
    check("rst_fifo_cnt", 64'(fifo_cnt), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_ovf", 64'(ovf), 64'(0));

    // Single word, table driven
    sd_data = 48'h0123_4567_89AB;
    rdy     = 1'b1;
    for (int e = 0; e < 22; e++) begin
      sd_data_vld = tbl[e].vld;
      step();
      check("tbl_dout_vld", 64'(dout_vld), 64'(tbl[e].exp_vld));
      check("tbl_dout", 64'(dout), 64'(tbl[e].exp_dout));
      check("tbl_fifo_cnt", 64'(fifo_cnt), 64'(tbl[e].exp_cnt));
      check("tbl_busy", 64'(busy), 64'(tbl[e].exp_busy));
    end
    sd_data_vld = 1'b0;

    // Backpressure: rdy low through edge 40, first byte on edge 41
    do_reset();
    cnt = 0;
    sd_data_vld = 1'b1;
    sd_data     = 48'h0123_4567_89AB;
    step();
    sd_data_vld = 1'b0;
    for (int e = 1; e <= 40; e++) begin
      step();
      if (dout_vld) cnt++;
    end
    check("bp_no_strobe", 64'(cnt), 64'(0));
    rdy = 1'b1;
    step();
    check("bp_first_vld", 64'(dout_vld), 64'(1));
    check("bp_first_byte", 64'(dout), 64'(8'h01));
    drain(200);
    ws.delete();
    ws.push_back(48'h0123_4567_89AB);
    check_got(ws);

    // Overflow: 17 words fill shift register + FIFO, the 18th is dropped
    do_reset();
    ws.delete();
    for (int i = 0; i < 17; i++) begin
      w = rand_word();
      ws.push_back(w);
      push_word(w);
    end
    check("ovf_cnt_full", 64'(fifo_cnt), 64'(16));
    check("ovf_clear", 64'(ovf), 64'(0));
    push_word(rand_word());
    check("ovf_set", 64'(ovf), 64'(1));
    check("ovf_cnt_hold", 64'(fifo_cnt), 64'(16));
    rdy = 1'b1;
    drain(1000);
    check_got(ws);
    check("ovf_sticky", 64'(ovf), 64'(1));

    // Push coincident with pop at fifo_cnt = 3
    do_reset();
    ws.delete();
    for (int i = 0; i < 4; i++) begin
      w = rand_word();
      ws.push_back(w);
      push_word(w);
    end
    check("pp_cnt_pre", 64'(fifo_cnt), 64'(3));
    rdy = 1'b1;
    wait_strobes(6, 100);
    step();
    step();
    w = rand_word();
    ws.push_back(w);
    push_word(w);
    check("pp_cnt_same", 64'(fifo_cnt), 64'(3));
    check("pp_no_ovf", 64'(ovf), 64'(0));
    drain(500);
    check_got(ws);

    // Full FIFO with push and pop on the same edge: word dropped
    do_reset();
    ws.delete();
    for (int i = 0; i < 17; i++) begin
      w = rand_word();
      ws.push_back(w);
      push_word(w);
    end
    check("fpp_cnt_full", 64'(fifo_cnt), 64'(16));
    rdy = 1'b1;
    wait_strobes(6, 100);
    step();
    step();
    push_word(rand_word());
    check("fpp_cnt", 64'(fifo_cnt), 64'(15));
    check("fpp_ovf", 64'(ovf), 64'(1));
    drain(1000);
    check_got(ws);

    // Reset after the third byte with 4 words queued
    do_reset();
    for (int i = 0; i < 5; i++) push_word(rand_word());
    check("mr_cnt_pre", 64'(fifo_cnt), 64'(4));
    rdy = 1'b1;
    wait_strobes(3, 100);
    rst_n = 1'b0;
    #1;
    check("mr_dout", 64'(dout), 64'(0));
    check("mr_dout_vld", 64'(dout_vld), 64'(0));
    check("mr_fifo_cnt", 64'(fifo_cnt), 64'(0));
    check("mr_busy", 64'(busy), 64'(0));
    check("mr_ovf", 64'(ovf), 64'(0));
    step();
    rst_n = 1'b1;
    cnt = 0;
    for (int e = 0; e < 100; e++) begin
      step();
      if (dout_vld) cnt++;
    end
    check("mr_quiet", 64'(cnt), 64'(0));

    // Randomized traffic with phases of light and heavy backpressure
    do_reset();
    for (int blk = 0; blk < 15; blk++) begin
      int rdy_pct;
      int vld_pct;
      rdy_pct = $urandom_range(0, 100);
      vld_pct = $urandom_range(5, 60);
      for (int c = 0; c < 200; c++) begin
        rdy         = ($urandom_range(0, 99) < rdy_pct);
        sd_data_vld = ($urandom_range(0, 99) < vld_pct);
        sd_data     = rand_word();
        step();
      end
    end
    sd_data_vld = 1'b0;
    rdy = 1'b1;
    drain(1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
